imem_program_loader: RTL and testbench
======================================

// Module: imem_program_loader
// PURPOSE
//  Synthesisable program loader. Streams instruction words into the CPU instruction memory over a valid/ready port.
//  Drives the CPU's initialize and rst inputs, replacing bench-driven instruction_initialize_* poking.
//  Addressing: auto-increment from a base address, or an explicit address per word.
//  Releases the CPU a fixed number of cycles after the last word; can reload while the CPU runs.
// PARAMETERS
//  DATA_W         32   instruction word width
//  ADDR_W         32   instruction address width (byte address when BYTE_ADDR=1)
//  DEPTH          256  instruction memory depth in words; legal word index 0..DEPTH-1
//  BYTE_ADDR      1    1: address step 4, bits[1:0] must be 0; 0: word address, step 1
//  RELEASE_DELAY  2    cycles between last imem write and CPU release (>=1)
// PORTS
//  clk          in   1                   system clock
//  rst          in   1                   synchronous, active-high reset
//  start        in   1                   begin a load session (sampled in IDLE/RUN only)
//  auto_inc     in   1                   latched at start: 1=auto-increment, 0=use s_addr
//  base_addr    in   ADDR_W              latched at start; first auto-increment address
//  s_valid      in   1                   word available
//  s_ready      out  1                   loader accepts word
//  s_data       in   DATA_W              instruction word
//  s_addr       in   ADDR_W              explicit address (auto_inc=0 only)
//  s_last       in   1                   final word of session
//  imem_we      out  1                   instruction memory write strobe
//  imem_addr    out  ADDR_W              write address
//  imem_wdata   out  DATA_W              write data
//  initialize   out  1                   to cpu.initialize
//  cpu_rst      out  1                   to cpu.rst
//  busy         out  1                   state is LOAD or FLUSH
//  done         out  1                   one-cycle pulse on CPU release
//  err          out  1                   sticky: a word was dropped
//  word_count   out  $clog2(DEPTH+1)     words written in current session
// BEHAVIOUR
//  Reset: state=IDLE, initialize=1, cpu_rst=1, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0,
//   busy=0, done=0, err=0, word_count=0. rst mid-session aborts it; registered write in flight is dropped.
//  FSM: IDLE -start-> LOAD; LOAD -accept with s_last-> FLUSH; FLUSH -RELEASE_DELAY cycles-> RUN;
//   RUN -start-> LOAD. start is ignored in LOAD and FLUSH.
//  On start: latch auto_inc/base_addr; clear word_count and err; initialize=1 and cpu_rst=1 next cycle.
//  LOAD: s_ready=1. Accept = s_valid & s_ready. Accepted word drives imem_we/addr/wdata on the next cycle (1-cycle latency).
//  Address: auto_inc -> base + word_count*(BYTE_ADDR?4:1); else s_addr.
//  Drop (no imem_we, no count, err<=1, handshake still completes):
//   word index >= DEPTH; BYTE_ADDR=1 and addr[1:0]!=0. s_last still honoured on a dropped word.
//  word_count increments only on performed writes; saturates at DEPTH.
//  Auto-inc with word_count==DEPTH: next word drops as out of range.
//  FLUSH: s_ready=0; initialize=cpu_rst=1; counter runs RELEASE_DELAY cycles from the cycle after the last accept.
//  RUN entry: initialize=0, cpu_rst=0, done=1 for that cycle only. Outputs stay until next start or rst.
//  busy = (state==LOAD || state==FLUSH).
// STRUCTURE
//  Package loader_pkg: state enum {IDLE,LOAD,FLUSH,RUN}; ADDR_STEP function of BYTE_ADDR; WORD_SHIFT constant.
//  Sub-module loader_addr_gen: base/auto_inc latch, address compute, range/alignment check (combinational + latch).
//  Top: FSM, write register stage, release counter, status flags.
// TESTING
//  1 Reset 3 cycles -> initialize=1, cpu_rst=1, s_ready=0, imem_we=0, err=0, word_count=0.
//  2 start, auto_inc=1, base=0; send 0x00021020, 0x00021020, 0x0BFFFFFD (last)
//     -> writes at 0,4,8 one cycle after each accept; word_count=3; cpu_rst falls 2 cycles after the last write; done pulses once.
//  3 auto_inc=0; addresses 0x10, 0x14 with s_valid gaps of 2 cycles
//     -> imem_we only on cycles following accepts, at 0x10/0x14.
//  4 Explicit addr 4*DEPTH, then 0x6 -> no imem_we for either word; err=1 sticky; word_count unchanged.
//  5 rst asserted after 2nd accept of a 4-word load -> IDLE; no further imem_we; all outputs at reset values.
//  6 start in RUN -> cpu_rst and initialize reassert next cycle; new load completes; start during FLUSH ignored.

Source files
------------

// File: rtl/imem_program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The FSM state encoding and address-step helpers live here.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_e;

  // log2 of bytes per instruction word in byte-addressed mode
  localparam int WORD_SHIFT = 2;

  function automatic int addr_step(input int byte_addr);
    return (byte_addr != 0) ? (1 << WORD_SHIFT) : 1;
  endfunction

endpackage

// File: rtl/imem_program_loader_addr_gen.sv
// Latches the session addressing mode and base, then produces the write
// address for the word on the stream plus a drop flag for bad addresses.
module loader_addr_gen
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 256,
  parameter int BYTE_ADDR = 1,
  parameter int CNT_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_latch,
  input  logic              i_auto_inc,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_s_addr,
  input  logic [CNT_W-1:0]  i_word_count,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_drop
);

  logic              r_auto_inc;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_index;
  logic              w_out_of_range;
  logic              w_misaligned;
  logic              w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_auto_inc <= 1'b0;
      r_base     <= '0;
    end else if (i_latch) begin
      r_auto_inc <= i_auto_inc;
      r_base     <= i_base_addr;
    end
  end

  assign w_offset = ADDR_W'(i_word_count) * ADDR_W'(addr_step(BYTE_ADDR));
  assign o_addr   = r_auto_inc ? (r_base + w_offset) : i_s_addr;

  // Range is checked on the absolute word index, not relative to the base.
  assign w_index        = (BYTE_ADDR != 0) ? (o_addr >> WORD_SHIFT) : o_addr;
  assign w_full         = r_auto_inc && (i_word_count == CNT_W'(DEPTH));
  assign w_out_of_range = (w_index >= ADDR_W'(DEPTH)) || w_full;
  assign w_misaligned   = (BYTE_ADDR != 0) && (o_addr[1:0] != 2'b00);
  assign o_drop         = w_out_of_range || w_misaligned;

endmodule

// File: rtl/imem_program_loader.sv
// Program loader: streams instruction words into the CPU instruction memory
// and holds the CPU in reset/initialize until the load has settled.
module imem_program_loader
  import loader_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int DEPTH         = 256,
  parameter int BYTE_ADDR     = 1,
  parameter int RELEASE_DELAY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       auto_inc,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  input  logic [ADDR_W-1:0]          s_addr,
  input  logic                       s_last,
  output logic                       imem_we,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic [DATA_W-1:0]          imem_wdata,
  output logic                       initialize,
  output logic                       cpu_rst,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] word_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int REL_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

  state_e            r_state;
  state_e            w_state_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_done;
  logic              r_err;
  logic [CNT_W-1:0]  r_word_count;
  logic [REL_W-1:0]  r_rel_cnt;

  logic              w_start;
  logic              w_accept;
  logic              w_write;
  logic              w_drop;
  logic [ADDR_W-1:0] w_addr;

  loader_addr_gen #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BYTE_ADDR (BYTE_ADDR),
    .CNT_W     (CNT_W)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .i_latch      (w_start),
    .i_auto_inc   (auto_inc),
    .i_base_addr  (base_addr),
    .i_s_addr     (s_addr),
    .i_word_count (r_word_count),
    .o_addr       (w_addr),
    .o_drop       (w_drop)
  );

  assign w_start  = start && ((r_state == IDLE) || (r_state == RUN));
  assign w_accept = s_valid && s_ready;
  assign w_write  = w_accept && !w_drop;

  always_comb begin
    w_state_next = r_state;
    s_ready      = 1'b0;
    busy         = 1'b0;
    initialize   = 1'b1;
    cpu_rst      = 1'b1;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (w_accept && s_last) w_state_next = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (r_rel_cnt == REL_W'(RELEASE_DELAY - 1)) w_state_next = RUN;
      end
      RUN: begin
        initialize = 1'b0;
        cpu_rst    = 1'b0;
        if (start) w_state_next = LOAD;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
      r_rel_cnt    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_we      <= w_write;
      r_done    <= (r_state == FLUSH) && (w_state_next == RUN);
      r_rel_cnt <= (r_state == FLUSH) ? r_rel_cnt + 1'b1 : '0;
      if (w_write) begin
        r_addr  <= w_addr;
        r_wdata <= s_data;
      end
      // A dropped word still completes its handshake; it only flags err.
      if (w_start) begin
        r_word_count <= '0;
        r_err        <= 1'b0;
      end else if (w_accept) begin
        if (w_drop) begin
          r_err <= 1'b1;
        end else if (r_word_count != CNT_W'(DEPTH)) begin
          r_word_count <= r_word_count + 1'b1;
        end
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: each task drives one scenario and
// checks the logged imem writes and status outputs against hand-computed values.
module tb_imem_program_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 256;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              auto_inc;
  logic [ADDR_W-1:0] base_addr;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [ADDR_W-1:0] s_addr;
  logic              s_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              initialize;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  word_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  int                wr_cyc[$];
  int                done_cnt = 0;
  int                fall_cyc = -1;
  logic              prev_cpu_rst = 1'b1;

  always #5 clk = ~clk;

  imem_program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .auto_inc   (auto_inc),
    .base_addr  (base_addr),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_addr     (s_addr),
    .s_last     (s_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .initialize (initialize),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Write/release log, sampled on the falling edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
      $display("write  cyc=%0d addr=%h data=%h", cyc, imem_addr, imem_wdata);
    end
    if (done === 1'b1) done_cnt++;
    if (prev_cpu_rst === 1'b1 && cpu_rst === 1'b0) fall_cyc = cyc;
    prev_cpu_rst = cpu_rst;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
    fall_cyc = -1;
  endtask

  task automatic do_start(input logic ai, input logic [ADDR_W-1:0] base);
    start     = 1'b1;
    auto_inc  = ai;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one word and return the cycle in which the handshake completed.
  task automatic send(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                      input logic last, output int acc);
    s_valid = 1'b1;
    s_addr  = addr;
    s_data  = data;
    s_last  = last;
    acc     = -1;
    for (int n = 0; n < 50; n++) begin
      if (s_ready === 1'b1) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL send_timeout: s_ready=%b after 50 cycles, required 1", s_ready);
    end else begin
      $display("accept cyc=%0d addr=%h data=%h last=%b", acc, addr, data, last);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 30; n++) begin
      if (done_cnt > 0) break;
      @(negedge clk);
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout: done never pulsed within 30 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({initialize, cpu_rst, s_ready, imem_we, busy, done, err} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_flags: got init/rst/rdy/we/busy/done/err=%b required 1100000",
               {initialize, cpu_rst, s_ready, imem_we, busy, done, err});
    end
    checks++;
    if (word_count !== '0 || imem_addr !== '0 || imem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_regs: wc=%0d addr=%h wdata=%h required 0/0/0",
               word_count, imem_addr, imem_wdata);
    end
    rst = 1'b0;
    idle(2);
    checks++;
    if ({cpu_rst, s_ready, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_idle: got cpu_rst/rdy/busy=%b required 100", {cpu_rst, s_ready, busy});
    end
  endtask

  task automatic test_auto_load();
    int acc[3];
    logic [DATA_W-1:0] d[3];
    d[0] = 32'h0002_1020;
    d[1] = 32'h0002_1020;
    d[2] = 32'h0BFF_FFFD;
    clear_log();
    do_start(1'b1, 32'h0);
    checks++;
    if ({initialize, cpu_rst, busy, s_ready} !== 4'b1111) begin
      errors++;
      $display("FAIL auto_load_state: init/rst/busy/rdy=%b required 1111",
               {initialize, cpu_rst, busy, s_ready});
    end
    for (int i = 0; i < 3; i++) send(ADDR_W'(32'hDEAD_0000), d[i], (i == 2), acc[i]);
    wait_done();
    idle(3);
    checks++;
    if (wr_addr.size() != 3) begin
      errors++;
      $display("FAIL auto_load_count: got %0d writes required 3", wr_addr.size());
    end
    for (int i = 0; i < wr_addr.size() && i < 3; i++) begin
      checks++;
      if (wr_addr[i] !== ADDR_W'(4 * i) || wr_data[i] !== d[i] || wr_cyc[i] != acc[i] + 1) begin
        errors++;
        $display("FAIL auto_load_write[%0d]: addr=%h data=%h cyc=%0d required %h/%h/%0d",
                 i, wr_addr[i], wr_data[i], wr_cyc[i], 4 * i, d[i], acc[i] + 1);
      end
    end
    checks++;
    if (word_count !== CNT_W'(3)) begin
      errors++;
      $display("FAIL auto_load_wc: got %0d required 3", word_count);
    end
    if (wr_cyc.size() == 3) begin
      checks++;
      if (fall_cyc != wr_cyc[2] + 2) begin
        errors++;
        $display("FAIL auto_load_release: cpu_rst fell at %0d required %0d", fall_cyc, wr_cyc[2] + 2);
      end
    end
    checks++;
    if (done_cnt != 1 || {initialize, cpu_rst, busy} !== 3'b000) begin
      errors++;
      $display("FAIL auto_load_run: done pulses=%0d init/rst/busy=%b required 1 and 000",
               done_cnt, {initialize, cpu_rst, busy});
    end
  endtask

  task automatic test_explicit_gaps();
    int a0, a1;
    clear_log();
    do_start(1'b0, 32'h0000_0400);
    checks++;
    if ({initialize, cpu_rst} !== 2'b11 || word_count !== '0) begin
      errors++;
      $display("FAIL explicit_start: init/rst=%b wc=%0d required 11 and 0", {initialize, cpu_rst}, word_count);
    end
    idle(2);
    send(32'h10, 32'hA5A5_0001, 1'b0, a0);
    idle(2);
    send(32'h14, 32'hA5A5_0002, 1'b1, a1);
    wait_done();
    idle(2);
    checks++;
    if (wr_addr.size() != 2) begin
      errors++;
      $display("FAIL explicit_count: got %0d writes required 2", wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 32'h10 || wr_cyc[0] != a0 + 1 || wr_data[0] !== 32'hA5A5_0001) begin
        errors++;
        $display("FAIL explicit_w0: addr=%h cyc=%0d data=%h required 10/%0d/a5a50001",
                 wr_addr[0], wr_cyc[0], wr_data[0], a0 + 1);
      end
      checks++;
      if (wr_addr[1] !== 32'h14 || wr_cyc[1] != a1 + 1 || wr_data[1] !== 32'hA5A5_0002) begin
        errors++;
        $display("FAIL explicit_w1: addr=%h cyc=%0d data=%h required 14/%0d/a5a50002",
                 wr_addr[1], wr_cyc[1], wr_data[1], a1 + 1);
      end
    end
    checks++;
    if (word_count !== CNT_W'(2) || err !== 1'b0) begin
      errors++;
      $display("FAIL explicit_status: wc=%0d err=%b required 2 and 0", word_count, err);
    end
  endtask

  task automatic test_drops();
    int a0, a1;
    clear_log();
    do_start(1'b0, 32'h0);
    send(ADDR_W'(4 * DEPTH), 32'h1234_5678, 1'b0, a0);
    send(32'h6, 32'h8765_4321, 1'b1, a1);
    wait_done();
    idle(2);
    checks++;
    if (wr_addr.size() != 0) begin
      errors++;
      $display("FAIL drop_writes: got %0d writes required 0", wr_addr.size());
    end
    checks++;
    if (err !== 1'b1 || word_count !== '0) begin
      errors++;
      $display("FAIL drop_status: err=%b wc=%0d required 1 and 0", err, word_count);
    end
    idle(3);
    checks++;
    if (err !== 1'b1 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL drop_sticky: err=%b cpu_rst=%b required 1 and 0", err, cpu_rst);
    end
  endtask

  task automatic test_restart_in_run();
    int a0, a1;
    clear_log();
    checks++;
    if (cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL restart_pre: cpu_rst=%b required 0", cpu_rst);
    end
    do_start(1'b1, 32'h40);
    checks++;
    if ({initialize, cpu_rst, busy} !== 3'b111 || err !== 1'b0 || word_count !== '0) begin
      errors++;
      $display("FAIL restart_reassert: init/rst/busy=%b err=%b wc=%0d required 111/0/0",
               {initialize, cpu_rst, busy}, err, word_count);
    end
    send(32'h0, 32'h1111_1111, 1'b0, a0);
    send(32'h0, 32'h2222_2222, 1'b1, a1);
    do_start(1'b0, 32'h80);
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_flush_ignore: busy=%b s_ready=%b required 1 and 0", busy, s_ready);
    end
    wait_done();
    idle(4);
    checks++;
    if ({cpu_rst, busy} !== 2'b00 || done_cnt != 1 || word_count !== CNT_W'(2)) begin
      errors++;
      $display("FAIL restart_run: rst/busy=%b done=%0d wc=%0d required 00/1/2",
               {cpu_rst, busy}, done_cnt, word_count);
    end
    checks++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 32'h40 || wr_addr[wr_addr.size() - 1] !== 32'h44) begin
      errors++;
      $display("FAIL restart_writes: n=%0d first=%h required 2 writes at 40/44",
               wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 32'hx);
    end
  endtask

  task automatic test_mid_reset();
    int a0, a1;
    clear_log();
    do_start(1'b1, 32'h100);
    send(32'h0, 32'hCAFE_0000, 1'b0, a0);
    send(32'h0, 32'hCAFE_0001, 1'b0, a1);
    // Third word is offered in the same cycle rst asserts; it must not land.
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hCAFE_0002;
    idle(3);
    rst = 1'b0;
    idle(3);
    s_valid = 1'b0;
    idle(1);
    checks++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 32'h100 || wr_addr[wr_addr.size() - 1] !== 32'h104) begin
      errors++;
      $display("FAIL mid_reset_writes: got %0d writes required 2 at 100/104", wr_addr.size());
    end
    checks++;
    if ({initialize, cpu_rst, s_ready, imem_we, busy, done, err} !== 7'b1100000) begin
      errors++;
      $display("FAIL mid_reset_flags: init/rst/rdy/we/busy/done/err=%b required 1100000",
               {initialize, cpu_rst, s_ready, imem_we, busy, done, err});
    end
    checks++;
    if (word_count !== '0 || imem_addr !== '0 || imem_wdata !== '0) begin
      errors++;
      $display("FAIL mid_reset_regs: wc=%0d addr=%h wdata=%h required 0/0/0",
               word_count, imem_addr, imem_wdata);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    auto_inc  = 1'b0;
    base_addr = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_addr    = '0;
    s_last    = 1'b0;
    @(negedge clk);
    test_reset();
    test_auto_load();
    test_explicit_gaps();
    test_drops();
    test_restart_in_run();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
